// File: rtl/dma_ctrl.sv
// ============================================================================
// dma_ctrl : single-channel disk-to-memory DMA engine, one word per handshake
// Rev 1.0  : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dma_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_AW    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_wr,
  input  logic [31:0]       reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              disk_rd_req,
  output logic [31:0]       disk_addr,
  input  logic [31:0]       disk_rdata,
  input  logic              disk_rd_ack,
  output logic              mem_wr_req,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wr_ack,
  output logic              dma_busy,
  output logic              dma_irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRD  = 2'd1;
  localparam logic [1:0] S_MWR  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] A_DISK = BASE_ADDR;
  localparam logic [31:0] A_MEM  = BASE_ADDR + 32'h4;
  localparam logic [31:0] A_SIZE = BASE_ADDR + 32'h8;
  localparam logic [31:0] A_INIT = BASE_ADDR + 32'hC;

  logic [1:0]        state;
  logic [31:0]       disk_addr_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [15:0]       t_size_q;
  logic [31:0]       cur_disk;
  logic [MEM_AW-1:0] cur_mem;
  logic [13:0]       cnt;
  logic [31:0]       word_buf;
  logic              irq_q;

  logic        idle;
  logic        wr_init;
  logic        start;
  logic [13:0] word_cnt;

  assign idle     = (state == S_IDLE);
  assign wr_init  = reg_wr && (reg_addr == A_INIT);
  assign start    = wr_init && reg_wdata[0] && idle;
  assign word_cnt = t_size_q[15:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      disk_addr_q <= '0;
      mem_addr_q  <= '0;
      t_size_q    <= '0;
      cur_disk    <= '0;
      cur_mem     <= '0;
      cnt         <= '0;
      word_buf    <= '0;
      irq_q       <= 1'b0;
    end else begin
      // Programming registers are frozen while a transfer is in flight.
      if (reg_wr && idle) begin
        if (reg_addr == A_DISK) disk_addr_q <= reg_wdata;
        if (reg_addr == A_MEM)  mem_addr_q  <= reg_wdata[MEM_AW-1:0];
        if (reg_addr == A_SIZE) t_size_q    <= reg_wdata[15:0];
      end

      // Completion set takes priority over a software clear in the same cycle.
      if (state == S_DONE) irq_q <= 1'b1;
      else if (wr_init)    irq_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (word_cnt != 14'd0) begin
              cur_disk <= disk_addr_q;
              cur_mem  <= mem_addr_q;
              cnt      <= word_cnt;
              state    <= S_DRD;
            end else begin
              state    <= S_DONE;
            end
          end
        end
        S_DRD: begin
          if (disk_rd_ack) begin
            word_buf <= disk_rdata;
            state    <= S_MWR;
          end
        end
        S_MWR: begin
          if (mem_wr_ack) begin
            cur_disk <= cur_disk + 32'd4;
            cur_mem  <= cur_mem + MEM_AW'(4);
            cnt      <= cnt - 14'd1;
            state    <= (cnt == 14'd1) ? S_DONE : S_DRD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign disk_rd_req = (state == S_DRD);
  assign disk_addr   = cur_disk;
  assign mem_wr_req  = (state == S_MWR);
  assign mem_addr    = cur_mem;
  assign mem_wdata   = word_buf;
  assign dma_busy    = !idle;
  assign dma_irq     = irq_q;

  always_comb begin
    reg_rdata = 32'd0;
    if (reg_addr == A_DISK) reg_rdata = disk_addr_q;
    if (reg_addr == A_MEM)  reg_rdata = 32'(mem_addr_q);
    if (reg_addr == A_SIZE) reg_rdata = {16'd0, t_size_q};
    if (reg_addr == A_INIT) reg_rdata = {30'd0, irq_q, dma_busy};
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_ctrl.sv
// ============================================================================
// tb_dma_ctrl : directed bench for dma_ctrl with disk/memory responders
// Rev 1.0     : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dma_ctrl;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          MEM_AW = 15;
  localparam logic [31:0] R_DISK = BASE;
  localparam logic [31:0] R_MEM  = BASE + 32'h4;
  localparam logic [31:0] R_SIZE = BASE + 32'h8;
  localparam logic [31:0] R_INIT = BASE + 32'hC;

  logic              clk = 1'b0;
  logic              rst;
  logic              reg_wr;
  logic [31:0]       reg_addr;
  logic [31:0]       reg_wdata;
  logic [31:0]       reg_rdata;
  logic              disk_rd_req;
  logic [31:0]       disk_addr;
  logic [31:0]       disk_rdata;
  logic              disk_rd_ack;
  logic              mem_wr_req;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_wr_ack;
  logic              dma_busy;
  logic              dma_irq;

  logic d_ack;
  logic stray_ack;
  assign disk_rd_ack = d_ack | stray_ack;

  always #5 clk = ~clk;

  dma_ctrl #(.BASE_ADDR(BASE), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .disk_rd_req(disk_rd_req), .disk_addr(disk_addr), .disk_rdata(disk_rdata),
    .disk_rd_ack(disk_rd_ack),
    .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_ack(mem_wr_ack),
    .dma_busy(dma_busy), .dma_irq(dma_irq)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int max_dly  = 0;
  logic mem_hold = 1'b0;
  logic [31:0] disk_base = 32'd0;

  logic [MEM_AW-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Disk model: word n of the current block reads back as A0A0_0000 + n + 1.
  function automatic logic [31:0] disk_word(input logic [31:0] a);
    return 32'hA0A0_0000 + ((a - disk_base) >> 2) + 32'd1;
  endfunction

  // Bus responders: randomised ack latency, driven just after each rising edge.
  initial begin
    int d_wait = 0, m_wait = 0, d_dly = 0, m_dly = 0;
    d_ack = 1'b0; mem_wr_ack = 1'b0; disk_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk); #1;
      d_ack = 1'b0; mem_wr_ack = 1'b0; disk_rdata = 32'hDEAD_BEEF;
      if (disk_rd_req && !rst) begin
        if (d_wait >= d_dly) begin
          d_ack = 1'b1; disk_rdata = disk_word(disk_addr);
          d_wait = 0; d_dly = $urandom_range(max_dly, 0);
        end else d_wait++;
      end
      if (mem_hold) m_wait = 0;
      else if (mem_wr_req && !rst) begin
        if (m_wait >= m_dly) begin
          mem_wr_ack = 1'b1;
          m_wait = 0; m_dly = $urandom_range(max_dly, 0);
        end else m_wait++;
      end
    end
  end

  // Protocol monitor and scoreboard, sampled on the falling edge.
  initial begin
    logic p_rd = 0, p_rd_ack = 0, p_wr = 0, p_wr_ack = 0, p_rst = 1;
    logic [31:0] p_daddr = 0, p_wdata = 0;
    logic [MEM_AW-1:0] p_maddr = 0;
    forever begin
      @(negedge clk);
      if (!rst && !p_rst) begin
        if (disk_rd_req || mem_wr_req) check("req_overlap", {disk_rd_req, mem_wr_req} == 2'b11, 0);
        if (p_rd && !p_rd_ack) begin
          check("rd_req_held", disk_rd_req, 1);
          check("disk_addr_stable", disk_addr, p_daddr);
        end
        if (p_wr && !p_wr_ack) begin
          check("wr_req_held", mem_wr_req, 1);
          check("mem_addr_stable", mem_addr, p_maddr);
          check("mem_wdata_stable", mem_wdata, p_wdata);
        end
        if (mem_wr_req && mem_wr_ack) begin
          wr_count++;
          n_assert++;
          assert (exp_addr.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_extra_write: observed addr 0x%0h data 0x%0h expected no write", mem_addr, mem_wdata);
          end
          if (exp_addr.size() != 0) begin
            check("sb_addr", mem_addr, exp_addr.pop_front());
            check("sb_data", mem_wdata, exp_data.pop_front());
          end
        end
      end
      if (disk_rd_req && !p_rd) rd_pulses++;
      if (mem_wr_req && !p_wr) wr_pulses++;
      p_rd = disk_rd_req; p_rd_ack = disk_rd_ack; p_wr = mem_wr_req; p_wr_ack = mem_wr_ack;
      p_rst = rst; p_daddr = disk_addr; p_maddr = mem_addr; p_wdata = mem_wdata;
    end
  end

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_wr = 1'b0; reg_addr = 32'd0; reg_wdata = 32'd0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    reg_addr = a; #1;
    check(tag, reg_rdata, exp);
    reg_addr = 32'd0;
  endtask

  task automatic run_xfer(input logic [31:0] d, input logic [31:0] m, input logic [15:0] sz);
    disk_base = d;
    for (int i = 0; i < int'(sz >> 2); i++) begin
      exp_addr.push_back(MEM_AW'(m + 32'(4 * i)));
      exp_data.push_back(disk_word(d + 32'(4 * i)));
    end
    reg_write(R_DISK, d);
    reg_write(R_MEM, m);
    reg_write(R_SIZE, {16'd0, sz});
    reg_write(R_INIT, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (dma_busy === 1'b1 && n < 500) begin
      @(negedge clk); n++;
    end
    check(tag, n < 500, 1);
  endtask

  initial begin
    int w0, p0, k;
    rst = 1'b1; reg_wr = 1'b0; reg_addr = 32'd0; reg_wdata = 32'd0; stray_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", dma_busy, 0);
    check("rst_irq", dma_irq, 0);
    check("rst_rd_req", disk_rd_req, 0);
    check("rst_wr_req", mem_wr_req, 0);
    check("rst_disk_addr", disk_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    read_check("rst_reg_disk", R_DISK, 0);
    read_check("rst_reg_size", R_SIZE, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic 4-word copy with zero-wait acks.
    w0 = wr_count;
    run_xfer(32'h100, 32'h40, 16'h10);
    wait_idle("t1_timeout");
    check("t1_writes", wr_count - w0, 4);
    check("t1_sb_empty", exp_addr.size(), 0);
    check("t1_irq", dma_irq, 1);
    read_check("t1_status", R_INIT, 32'h2);
    read_check("t1_reg_mem", R_MEM, 32'h40);

    // Zero-length transfer: irq without bus activity, then software clear.
    p0 = rd_pulses + wr_pulses;
    reg_write(R_SIZE, 32'd0);
    reg_write(R_INIT, 32'd1);
    k = 0;
    while (dma_irq !== 1'b1 && k < 5) begin
      @(negedge clk); k++;
    end
    check("t2_irq_latency_ok", k <= 2, 1);
    check("t2_no_bus_pulses", rd_pulses + wr_pulses, p0);
    reg_write(R_INIT, 32'd0);
    @(negedge clk);
    check("t2_irq_cleared", dma_irq, 0);

    // Memory address wrap at the top of the window.
    w0 = wr_count;
    run_xfer(32'h1000, 32'h7FFC, 16'h8);
    wait_idle("t3_timeout");
    check("t3_writes", wr_count - w0, 2);
    check("t3_sb_empty", exp_addr.size(), 0);

    // Random ack latency on both buses.
    max_dly = 5;
    w0 = wr_count;
    run_xfer(32'h2000, 32'h200, 16'h20);
    wait_idle("t4_timeout");
    check("t4_writes", wr_count - w0, 8);
    check("t4_sb_empty", exp_addr.size(), 0);

    // Register writes and a restart while busy are ignored.
    max_dly = 3;
    w0 = wr_count;
    run_xfer(32'h200, 32'h100, 16'hC);
    @(negedge clk);
    check("t5_busy", dma_busy, 1);
    reg_write(R_DISK, 32'hFFFF);
    reg_write(R_INIT, 32'd1);
    wait_idle("t5_timeout");
    check("t5_writes", wr_count - w0, 3);
    check("t5_sb_empty", exp_addr.size(), 0);
    read_check("t5_reg_disk", R_DISK, 32'h200);
    max_dly = 0;

    // Reset while a memory write is pending.
    mem_hold = 1'b1;
    w0 = wr_count;
    run_xfer(32'h300, 32'h300, 16'h8);
    k = 0;
    while (mem_wr_req !== 1'b1 && k < 50) begin
      @(negedge clk); k++;
    end
    check("t6_reached_mwr", k < 50, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_wr_req", mem_wr_req, 0);
    check("t6_rd_req", disk_rd_req, 0);
    check("t6_busy", dma_busy, 0);
    check("t6_mem_addr", mem_addr, 0);
    read_check("t6_reg_disk", R_DISK, 0);
    read_check("t6_reg_mem", R_MEM, 0);
    read_check("t6_reg_size", R_SIZE, 0);
    read_check("t6_status", R_INIT, 0);
    check("t6_no_writes", wr_count - w0, 0);
    @(posedge clk); #1 rst = 1'b0;
    mem_hold = 1'b0;
    exp_addr.delete();
    exp_data.delete();

    // Size low bits ignored; stray disk ack in idle has no effect.
    w0 = wr_count;
    run_xfer(32'h400, 32'h600, 16'h0B);
    wait_idle("t7_timeout");
    check("t7_writes", wr_count - w0, 2);
    check("t7_sb_empty", exp_addr.size(), 0);
    @(posedge clk); #1 stray_ack = 1'b1;
    @(posedge clk); #1 stray_ack = 1'b0;
    @(negedge clk);
    check("t7_stray_busy", dma_busy, 0);
    check("t7_stray_rd_req", disk_rd_req, 0);
    check("t7_stray_wdata", mem_wdata, 32'hA0A0_0002);
    read_check("t7_status", R_INIT, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
